// File: rtl/rrat_commit_pkg.sv
// Shared rename/retire constants and types: register counts, tag types, recovery states.
package rrat_commit_pkg;

    localparam int unsigned NUM_AREG = 32;
    localparam int unsigned NUM_PREG = 64;
    localparam int unsigned AREG_W   = 5;
    localparam int unsigned PTAG_W   = 6;

    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PTAG_W-1:0] ptag_t;
    typedef logic [NUM_AREG-1:0][PTAG_W-1:0] rrat_map_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTORE = 2'd1,
        ST_SCAN    = 2'd2
    } rec_state_e;

    // Architectural register i maps to physical tag i out of reset.
    function automatic rrat_map_t identity_map();
        rrat_map_t m;
        for (int i = 0; i < int'(NUM_AREG); i++) begin
            m[i] = PTAG_W'(i);
        end
        return m;
    endfunction

    // The tags backing the identity map are the only ones in use out of reset.
    function automatic logic [NUM_PREG-1:0] in_use_at_reset();
        logic [NUM_PREG-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NUM_AREG); i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rrat_commit_preg_scan_ctr.sv
// Walks the physical-register bitmap once, emitting every tag that is not in use.
module rrat_commit_preg_scan_ctr
    import rrat_commit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_abort,
    input  logic [NUM_PREG-1:0] i_in_use,
    output logic                o_valid,
    output logic [PTAG_W-1:0]   o_ptag,
    output logic                o_last_c
);

    localparam ptag_t LAST_TAG = PTAG_W'(NUM_PREG - 1);

    logic  r_run;
    logic  r_valid;
    ptag_t r_cnt;
    ptag_t w_next;

    assign w_next   = r_cnt + PTAG_W'(1);
    assign o_last_c = r_run && (r_cnt == LAST_TAG);
    assign o_valid  = r_valid;
    assign o_ptag   = r_cnt;

    // r_cnt is the tag currently presented; the flag stops the pass at the last tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run   <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (i_abort) begin
            r_run   <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_run   <= 1'b1;
            r_valid <= !i_in_use[0];
            r_cnt   <= '0;
        end else if (r_run) begin
            if (r_cnt == LAST_TAG) begin
                r_run   <= 1'b0;
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_valid <= !i_in_use[w_next];
                r_cnt   <= w_next;
            end
        end
    end

endmodule

// File: rtl/rrat_commit.sv
// Retirement RAT: committed arch->phys map, superseded-tag frees and flush recovery.
module rrat_commit
    import rrat_commit_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              commit_valid,
    input  logic [AREG_W-1:0]                 commit_areg,
    input  logic [PTAG_W-1:0]                 commit_ptag,
    input  logic                              flush,
    output logic [NUM_AREG-1:0][PTAG_W-1:0]   rrat_map,
    output logic                              free_valid,
    output logic [PTAG_W-1:0]                 free_ptag,
    output logic                              rat_restore,
    output logic                              recover_busy,
    output logic                              recover_valid,
    output logic [PTAG_W-1:0]                 recover_ptag
);

    rec_state_e          r_state;
    rrat_map_t           r_map;
    logic [NUM_PREG-1:0] r_in_use;
    logic                r_free_valid;
    ptag_t               r_free_ptag;
    logic                r_rat_restore;
    logic                r_busy;

    logic  w_commit;
    logic  w_zero_dst;
    logic  w_do_free;
    ptag_t w_old;
    ptag_t w_free_tag;
    logic  w_scan_clear;
    logic  w_scan_abort;
    logic  w_scan_last;

    // Map writes land at the clock edge, so a following commit reads the updated entry.
    assign w_commit     = commit_valid && (r_state == ST_IDLE);
    assign w_zero_dst   = (commit_areg == '0);
    assign w_old        = r_map[commit_areg];
    assign w_do_free    = w_commit && (w_old != commit_ptag);
    assign w_free_tag   = w_zero_dst ? commit_ptag : w_old;

    assign w_scan_clear = (r_state == ST_RESTORE) && !flush;
    assign w_scan_abort = flush && (r_state != ST_IDLE);

    // Commit path: update map and bitmap, return the superseded (or dead) tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_map        <= identity_map();
            r_in_use     <= in_use_at_reset();
            r_free_valid <= 1'b0;
            r_free_ptag  <= '0;
        end else begin
            r_free_valid <= w_do_free;
            r_free_ptag  <= w_do_free ? w_free_tag : '0;
            if (w_do_free && !w_zero_dst) begin
                r_map[commit_areg]    <= commit_ptag;
                r_in_use[w_old]       <= 1'b0;
                r_in_use[commit_ptag] <= 1'b1;
            end
        end
    end

    // Recovery sequencer; a flush at any busy point restarts from RESTORE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rat_restore <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        r_state       <= ST_RESTORE;
                        r_rat_restore <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_RESTORE: begin
                    if (!flush) begin
                        r_state       <= ST_SCAN;
                        r_rat_restore <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (flush) begin
                        r_state       <= ST_RESTORE;
                        r_rat_restore <= 1'b1;
                    end else if (w_scan_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_rat_restore <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    rrat_commit_preg_scan_ctr u_scan (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_scan_clear),
        .i_abort  (w_scan_abort),
        .i_in_use (r_in_use),
        .o_valid  (recover_valid),
        .o_ptag   (recover_ptag),
        .o_last_c (w_scan_last)
    );

    // Every committed mapping owns exactly one tag while no recovery is in flight.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == ST_IDLE)) begin
            assert ($countones(r_in_use) == int'(NUM_AREG));
        end
    end

    assign rrat_map     = r_map;
    assign free_valid   = r_free_valid;
    assign free_ptag    = r_free_ptag;
    assign rat_restore  = r_rat_restore;
    assign recover_busy = r_busy;

endmodule

// File: tb/tb_rrat_commit.sv
// Directed bench for rrat_commit with a free/recover scoreboard and a reference map model.
module tb_rrat_commit;
    import rrat_commit_pkg::*;

    logic                            clk = 1'b0;
    logic                            reset = 1'b1;
    logic                            commit_valid = 1'b0;
    logic [AREG_W-1:0]               commit_areg = '0;
    logic [PTAG_W-1:0]               commit_ptag = '0;
    logic                            flush = 1'b0;
    logic [NUM_AREG-1:0][PTAG_W-1:0] rrat_map;
    logic                            free_valid;
    logic [PTAG_W-1:0]               free_ptag;
    logic                            rat_restore;
    logic                            recover_busy;
    logic                            recover_valid;
    logic [PTAG_W-1:0]               recover_ptag;

    int checks = 0;
    int errors = 0;
    int free_q[$];
    int rec_q[$];
    logic [NUM_AREG-1:0][PTAG_W-1:0] m_map;
    logic [NUM_PREG-1:0]             m_in_use;
    logic [NUM_PREG-1:0]             seen;
    int                              rec_pulses;

    always #5 clk = ~clk;

    rrat_commit dut (
        .clk           (clk),
        .reset         (reset),
        .commit_valid  (commit_valid),
        .commit_areg   (commit_areg),
        .commit_ptag   (commit_ptag),
        .flush         (flush),
        .rrat_map      (rrat_map),
        .free_valid    (free_valid),
        .free_ptag     (free_ptag),
        .rat_restore   (rat_restore),
        .recover_busy  (recover_busy),
        .recover_valid (recover_valid),
        .recover_ptag  (recover_ptag)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_map(input string tag);
        checks++;
        assert (rrat_map === m_map) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, rrat_map, m_map);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_AREG); i++) m_map[i] = PTAG_W'(i);
        m_in_use = '0;
        for (int i = 0; i < int'(NUM_AREG); i++) m_in_use[i] = 1'b1;
        free_q.delete();
        rec_q.delete();
        seen = '0;
        rec_pulses = 0;
    endtask

    // Reference commit: areg 0 is never remapped, so its incoming tag is simply returned.
    task automatic model_commit(input int a, input int p);
        int old;
        old = int'(m_map[a]);
        if (a == 0) begin
            if (p != 0) free_q.push_back(p);
        end else if (old != p) begin
            free_q.push_back(old);
            m_map[a] = PTAG_W'(p);
            m_in_use[old] = 1'b0;
            m_in_use[p] = 1'b1;
        end
    endtask

    task automatic model_flush();
        rec_q.delete();
        seen = '0;
        rec_pulses = 0;
        for (int t = 0; t < int'(NUM_PREG); t++) begin
            if (!m_in_use[t]) rec_q.push_back(t);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_commit(input int a, input int p, input logic f);
        commit_valid = 1'b1;
        commit_areg  = AREG_W'(a);
        commit_ptag  = PTAG_W'(p);
        flush        = f;
        model_commit(a, p);
        tick(1);
        commit_valid = 1'b0;
        flush        = 1'b0;
        if (f) model_flush();
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        model_flush();
    endtask

    // Scoreboard: pops expected frees and recover tags as the DUT presents them.
    always @(negedge clk) begin
        if (!reset) begin
            if (free_valid) begin
                if (free_q.size() == 0) check("free_unexpected", int'(free_ptag), -1);
                else check("free_ptag", int'(free_ptag), free_q.pop_front());
            end
            if (recover_valid) begin
                rec_pulses++;
                seen[recover_ptag] = 1'b1;
                if (rec_q.size() == 0) check("recover_unexpected", int'(recover_ptag), -1);
                else check("recover_ptag", int'(recover_ptag), rec_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        tick(3);
        reset = 1'b0;
        tick(1);
        check_map("reset_map");
        check("reset_free_valid", int'(free_valid), 0);
        check("reset_busy", int'(recover_busy), 0);
        check("reset_restore", int'(rat_restore), 0);
        check("reset_recover_valid", int'(recover_valid), 0);

        tick(10);
        check_map("idle_map");
        check("idle_free_valid", int'(free_valid), 0);

        do_commit(5, 40, 1'b0);
        check_map("commit_5_40_map");
        check("commit_5_40_free_valid", int'(free_valid), 1);

        do_commit(5, 41, 1'b0);
        check("b2b_first_free_valid", int'(free_valid), 1);
        do_commit(5, 42, 1'b0);
        check("b2b_second_free_valid", int'(free_valid), 1);
        check("b2b_second_free_ptag", int'(free_ptag), 41);
        check_map("b2b_map");
        tick(1);
        check("b2b_free_done", int'(free_valid), 0);

        do_commit(0, 50, 1'b0);
        check_map("areg0_map");
        check("areg0_free_ptag", int'(free_ptag), 50);
        tick(1);

        do_commit(7, 33, 1'b1);
        check("flush_restore", int'(rat_restore), 1);
        check("flush_busy", int'(recover_busy), 1);
        check_map("flush_map");
        check("flush_free_valid", int'(free_valid), 1);
        check("flush_free_ptag", int'(free_ptag), 7);
        tick(1);
        check("scan_restore_low", int'(rat_restore), 0);
        check("scan_first_ptag", int'(recover_ptag), 0);
        tick(63);
        check("scan_last_busy", int'(recover_busy), 1);
        check("scan_last_ptag", int'(recover_ptag), 63);
        tick(1);
        check("scan_done_busy", int'(recover_busy), 0);
        check("scan_done_valid", int'(recover_valid), 0);
        check("scan_pulse_count", rec_pulses, int'(NUM_PREG - NUM_AREG));
        check("scan_tag7_emitted", int'(seen[7]), 1);
        check("scan_tag33_not_emitted", int'(seen[33]), 0);
        check("scan_queue_drained", rec_q.size(), 0);

        pulse_flush();
        check("reflush_restore", int'(rat_restore), 1);
        tick(1);
        check("reflush_scan_start", int'(recover_ptag), 0);
        tick(20);
        check("scan20_ptag", int'(recover_ptag), 20);
        check("scan20_busy", int'(recover_busy), 1);
        pulse_flush();
        check("restart_restore", int'(rat_restore), 1);
        check("restart_valid", int'(recover_valid), 0);
        check("restart_ptag", int'(recover_ptag), 0);
        tick(1);
        check("restart_scan0_ptag", int'(recover_ptag), 0);
        tick(10);
        check("restart_scan10_ptag", int'(recover_ptag), 10);

        reset = 1'b1;
        #1;
        model_reset();
        check_map("midscan_reset_map");
        check("midscan_reset_busy", int'(recover_busy), 0);
        check("midscan_reset_restore", int'(rat_restore), 0);
        check("midscan_reset_valid", int'(recover_valid), 0);
        check("midscan_reset_ptag", int'(recover_ptag), 0);
        check("midscan_reset_free", int'(free_valid), 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("post_reset_busy", int'(recover_busy), 0);
        check("post_reset_valid", int'(recover_valid), 0);

        do_commit(3, 45, 1'b0);
        check_map("post_reset_commit_map");
        check("post_reset_free_ptag", int'(free_ptag), 3);
        tick(3);
        check("free_queue_drained", free_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rrat_commit.md
Name: rrat_commit

Overview:
Retirement RAT, directly downstream of the reorder buffer. It consumes the ROB's per-cycle commit remap (architectural reg, new physical tag) and holds the committed arch->phys map. It returns each superseded physical tag to rename's free list. On a ROB flush it restores rename's speculative RAT from the committed map, then streams every unallocated physical tag so rename can rebuild its free list.

Parameters:
NUM_AREG, 32, architectural registers (index width 5)
NUM_PREG, 64, physical registers (tag width 6)
AREG_W, 5, architectural index width
PTAG_W, 6, physical tag width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
commit_valid  in  1  ROB commit with register write (newMap flag)
commit_areg  in  5  architectural destination being committed
commit_ptag  in  6  physical tag now holding committed value
flush  in  1  ROB flush pulse (mispredict/syscall recovery)
rrat_map  out  32x6  committed map, registered, always visible
free_valid  out  1  superseded tag returned to free list
free_ptag  out  6  tag being freed
rat_restore  out  1  one-cycle pulse: rename copies rrat_map into its RAT
recover_busy  out  1  high from flush until free-list rebuild completes
recover_valid  out  1  recover_ptag is a free tag for rebuild
recover_ptag  out  6  free tag during rebuild scan

Behaviour:
- Reset (async, any cycle, including mid-scan): map[i]=i for i=0..31. in_use bitmap bits 0..31 = 1, bits 32..63 = 0. State = IDLE. All outputs 0 except rrat_map = identity.
- Commit in IDLE, commit_areg != 0:
  - map[areg] <= commit_ptag
  - in_use[commit_ptag] <= 1
  - in_use[old] <= 0, where old = map[areg] before the write
  - next cycle: free_valid=1, free_ptag=old (1-cycle latency, registered)
- If old == commit_ptag: map and bitmap unchanged, no free emitted.
- commit_areg == 0: map[0] is never written (stays tag 0). commit_ptag is freed next cycle (dead allocation).
- Back-to-back commits to the same areg: the second commit sees the first's write, i.e. forward the map value. Frees are emitted in commit order, one per cycle.
- States: IDLE -> RESTORE -> SCAN -> IDLE.
  - IDLE: flush=1 -> RESTORE. A commit in the same cycle as flush is applied first and is included in the restored map and bitmap.
  - RESTORE (1 cycle): rat_restore=1, recover_busy=1. The scan counter is cleared to 0. -> SCAN.
  - SCAN (exactly 64 cycles, counter 0..63): each cycle recover_valid = !in_use[cnt] and recover_ptag = cnt. Then cnt++. At cnt==63 -> IDLE. Busy is cleared on the cycle after the last scan cycle.
- Exactly NUM_PREG-NUM_AREG recover_valid pulses per scan, given the bitmap invariant (32 set bits).
- recover_busy=1 in RESTORE and SCAN.
- Commits while busy: ignored (no map/bitmap change, no free). The bench asserts this never occurs.
- flush while busy: restart at RESTORE. The counter is cleared and the partial scan is discarded.
- A free pending from the flush-cycle commit is still emitted the cycle after flush, concurrent with rat_restore.
- Counter is 7 bits, or 6 bits plus a done flag. Terminal compare is on 63; no wrap into a second pass.
- Invariant (assertion): popcount(in_use)==32 whenever state==IDLE.

Decomposition:
- Shared package: AREG_W, PTAG_W, NUM_AREG and NUM_PREG constants; the recover-state enum (IDLE/RESTORE/SCAN); the ptag type. The ROB and rename stage also use these.
- One natural sub-module: preg_scan_ctr, the 64-entry bitmap scanner producing recover_valid/recover_ptag and done. Map storage and the commit/free path stay in the top.

Test Plan:
- Reset -> rrat_map[i]==i, free_valid=0, recover_busy=0. After 10 idle cycles, still identity.
- Commit areg=5 ptag=40 -> map[5]=40; next cycle free_valid=1, free_ptag=5.
- Commit areg=5 ptag=41, then areg=5 ptag=42 on consecutive cycles -> frees 40 then 41 on consecutive cycles; map[5]=42.
- Commit areg=0 ptag=50 -> map[0] stays 0; next cycle free_ptag=50.
- Commit areg=7 ptag=33 together with flush:
  - next cycle: rat_restore=1 with map[7]=33, and free_ptag=7.
  - then 64 scan cycles with exactly 32 recover_valid pulses.
  - tag 7 is among the emitted tags; tag 33 is not.
  - recover_busy drops after cycle 65.
- flush at scan cycle 20, then reset asserted at scan cycle 10 of the restarted pass:
  - the flush restarts RESTORE and the scan from 0.
  - the reset immediately returns to identity map, IDLE, all outputs 0.
